map_blitter: RTL and testbench

- Owns the CPU-side (B) port of the 32x32 tile map RAM.
- Arbitrates that port between CPU bus accesses and an internal rectangle engine.
- The engine performs FILL (write a constant) and COPY (move tiles, used for scrolling) over a rectangular region, so the CPU does not loop over tiles.
- Sits between the bus decoder and the map RAM's B port, in the VGA block.

---
 rtl/map_pkg.sv | 19 +
 rtl/map_blitter_rect_scanner.sv | 46 ++++
 rtl/map_blitter.sv | 240 ++++++++++++++++++++++++
 tb/tb_map_blitter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/map_pkg.sv
// Shared constants and engine state encoding for the tile map blitter.
package map_pkg;

    localparam int MAP_ROWS = 32;
    localparam int MAP_COLS = 32;

    localparam logic MODE_FILL = 1'b0;
    localparam logic MODE_COPY = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FILL_WR   = 3'd1,
        COPY_RD   = 3'd2,
        COPY_WAIT = 3'd3,
        COPY_WR   = 3'd4,
        DONE      = 3'd5
    } eng_state_t;

endpackage

// File: rtl/map_blitter_rect_scanner.sv
// Row/column offset counters walking a rectangle column-first.
module rect_scanner #(
    parameter int ROW_W = 5,
    parameter int COL_W = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic             i_adv,
    input  logic [ROW_W:0]   i_rows,
    input  logic [COL_W:0]   i_cols,
    output logic [ROW_W-1:0] o_r,
    output logic [COL_W-1:0] o_c,
    output logic             o_last
);

    logic [ROW_W-1:0] r_r;
    logic [COL_W-1:0] r_c;
    logic             w_col_end;
    logic             w_row_end;

    assign w_col_end = ({1'b0, r_c} == (i_cols - {{COL_W{1'b0}}, 1'b1}));
    assign w_row_end = ({1'b0, r_r} == (i_rows - {{ROW_W{1'b0}}, 1'b1}));
    assign o_last    = w_col_end & w_row_end;
    assign o_r       = r_r;
    assign o_c       = r_c;

    // Offset counters: cleared on load, column steps first, row on column wrap.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_r <= {ROW_W{1'b0}};
            r_c <= {COL_W{1'b0}};
        end else if (i_load) begin
            r_r <= {ROW_W{1'b0}};
            r_c <= {COL_W{1'b0}};
        end else if (i_adv) begin
            if (w_col_end) begin
                r_c <= {COL_W{1'b0}};
                r_r <= r_r + {{(ROW_W-1){1'b0}}, 1'b1};
            end else begin
                r_c <= r_c + {{(COL_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/map_blitter.sv
// Map RAM B-port owner: CPU accesses with strict priority over a FILL/COPY
// rectangle engine. All RAM controls are registered single-cycle pulses.
module map_blitter
    import map_pkg::*;
#(
    parameter int ROW_W  = 5,
    parameter int COL_W  = 5,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_write,
    input  logic [ROW_W-1:0]  cpu_row,
    input  logic [COL_W-1:0]  cpu_col,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              eng_start,
    input  logic              eng_mode,
    input  logic [DATA_W-1:0] eng_value,
    input  logic [ROW_W-1:0]  eng_src_row,
    input  logic [COL_W-1:0]  eng_src_col,
    input  logic [ROW_W-1:0]  eng_dst_row,
    input  logic [COL_W-1:0]  eng_dst_col,
    input  logic [ROW_W:0]    eng_rows,
    input  logic [COL_W:0]    eng_cols,
    output logic              eng_busy,
    output logic              eng_done,
    output logic              map_cs,
    output logic              map_read,
    output logic              map_write,
    output logic [ROW_W-1:0]  map_row,
    output logic [COL_W-1:0]  map_col,
    output logic [DATA_W-1:0] map_wdata,
    input  logic [DATA_W-1:0] map_rdata
);

    localparam logic [ROW_W:0] ROW_LIM = (ROW_W+1)'(MAP_ROWS);
    localparam logic [COL_W:0] COL_LIM = (COL_W+1)'(MAP_COLS);

    eng_state_t        r_state, w_state_nx;
    logic              r_cpu_pend, r_cpu_rd, r_cpu_ack;
    logic [DATA_W-1:0] r_cpu_rdata, r_value, r_hold;
    logic [ROW_W-1:0]  r_src_row, r_dst_row, w_r;
    logic [COL_W-1:0]  r_src_col, r_dst_col, w_c;
    logic [ROW_W:0]    r_rows;
    logic [COL_W:0]    r_cols;
    logic              r_busy, r_done;
    logic              r_cs, r_rd, r_wr;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic [DATA_W-1:0] r_wdata;
    logic              w_cpu_take, w_start, w_eng_acc, w_eng_go, w_adv, w_last;
    logic              w_acc_rd, w_acc_wr;
    logic [ROW_W-1:0]  w_acc_row;
    logic [COL_W-1:0]  w_acc_col;
    logic [DATA_W-1:0] w_acc_data;

    // A CPU request is blocked while its previous access or ack is in flight.
    assign w_cpu_take = cpu_req & ~r_cpu_pend & ~r_cpu_ack;
    assign w_start    = eng_start & (r_state == IDLE);
    assign w_eng_acc  = (r_state == FILL_WR) | (r_state == COPY_RD) | (r_state == COPY_WR);
    assign w_eng_go   = w_eng_acc & ~w_cpu_take;
    assign w_adv      = w_eng_go & ((r_state == FILL_WR) | (r_state == COPY_WR));

    rect_scanner #(.ROW_W(ROW_W), .COL_W(COL_W)) u_scan (
        .clock   (clock),
        .reset_n (reset_n),
        .i_load  (w_start),
        .i_adv   (w_adv),
        .i_rows  (r_rows),
        .i_cols  (r_cols),
        .o_r     (w_r),
        .o_c     (w_c),
        .o_last  (w_last)
    );

    // CPU access pipeline: issue, then ack with captured read data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cpu_pend  <= 1'b0;
            r_cpu_rd    <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_cpu_rdata <= {DATA_W{1'b0}};
        end else begin
            r_cpu_pend  <= w_cpu_take;
            r_cpu_rd    <= w_cpu_take & ~cpu_write;
            r_cpu_ack   <= r_cpu_pend;
            r_cpu_rdata <= (r_cpu_pend & r_cpu_rd) ? map_rdata : {DATA_W{1'b0}};
        end
    end

    // Engine operand latches and the COPY holding register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_value   <= {DATA_W{1'b0}};
            r_src_row <= {ROW_W{1'b0}};
            r_src_col <= {COL_W{1'b0}};
            r_dst_row <= {ROW_W{1'b0}};
            r_dst_col <= {COL_W{1'b0}};
            r_rows    <= {(ROW_W+1){1'b0}};
            r_cols    <= {(COL_W+1){1'b0}};
            r_hold    <= {DATA_W{1'b0}};
        end else begin
            if (w_start) begin
                r_value   <= eng_value;
                r_src_row <= eng_src_row;
                r_src_col <= eng_src_col;
                r_dst_row <= eng_dst_row;
                r_dst_col <= eng_dst_col;
                r_rows    <= (eng_rows > ROW_LIM) ? ROW_LIM : eng_rows;
                r_cols    <= (eng_cols > COL_LIM) ? COL_LIM : eng_cols;
            end
            if (r_state == COPY_WAIT) begin
                r_hold <= map_rdata;
            end
        end
    end

    // Engine state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Engine next-state logic; access states hold while the CPU owns the port.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    if ((eng_rows == {(ROW_W+1){1'b0}}) || (eng_cols == {(COL_W+1){1'b0}})) begin
                        w_state_nx = DONE;
                    end else if (eng_mode == MODE_FILL) begin
                        w_state_nx = FILL_WR;
                    end else begin
                        w_state_nx = COPY_RD;
                    end
                end else begin
                    w_state_nx = IDLE;
                end
            end
            FILL_WR:   w_state_nx = (w_eng_go & w_last) ? DONE : FILL_WR;
            COPY_RD:   w_state_nx = w_eng_go ? COPY_WAIT : COPY_RD;
            COPY_WAIT: w_state_nx = COPY_WR;
            COPY_WR: begin
                if (w_eng_go) begin
                    w_state_nx = w_last ? DONE : COPY_RD;
                end else begin
                    w_state_nx = COPY_WR;
                end
            end
            DONE:      w_state_nx = IDLE;
            default:   w_state_nx = IDLE;
        endcase
    end

    // Engine access request for the current state, with wrapped addresses.
    always_comb begin
        w_acc_rd   = 1'b0;
        w_acc_wr   = 1'b0;
        w_acc_row  = r_dst_row + w_r;
        w_acc_col  = r_dst_col + w_c;
        w_acc_data = {DATA_W{1'b0}};
        case (r_state)
            FILL_WR: begin
                w_acc_wr   = 1'b1;
                w_acc_data = r_value;
            end
            COPY_RD: begin
                w_acc_rd  = 1'b1;
                w_acc_row = r_src_row + w_r;
                w_acc_col = r_src_col + w_c;
            end
            COPY_WR: begin
                w_acc_wr   = 1'b1;
                w_acc_data = r_hold;
            end
            default: begin
                w_acc_rd = 1'b0;
                w_acc_wr = 1'b0;
            end
        endcase
    end

    // RAM port register plus busy/done flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cs    <= 1'b0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_row   <= {ROW_W{1'b0}};
            r_col   <= {COL_W{1'b0}};
            r_wdata <= {DATA_W{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_busy <= (w_state_nx != IDLE);
            r_done <= (w_state_nx == DONE);
            if (w_cpu_take) begin
                r_cs    <= 1'b1;
                r_rd    <= ~cpu_write;
                r_wr    <= cpu_write;
                r_row   <= cpu_row;
                r_col   <= cpu_col;
                r_wdata <= cpu_write ? cpu_wdata : {DATA_W{1'b0}};
            end else if (w_eng_go) begin
                r_cs    <= 1'b1;
                r_rd    <= w_acc_rd;
                r_wr    <= w_acc_wr;
                r_row   <= w_acc_row;
                r_col   <= w_acc_col;
                r_wdata <= w_acc_data;
            end else begin
                r_cs    <= 1'b0;
                r_rd    <= 1'b0;
                r_wr    <= 1'b0;
                r_row   <= {ROW_W{1'b0}};
                r_col   <= {COL_W{1'b0}};
                r_wdata <= {DATA_W{1'b0}};
            end
        end
    end

    assign cpu_ack   = r_cpu_ack;
    assign cpu_rdata = r_cpu_rdata;
    assign eng_busy  = r_busy;
    assign eng_done  = r_done;
    assign map_cs    = r_cs;
    assign map_read  = r_rd;
    assign map_write = r_wr;
    assign map_row   = r_row;
    assign map_col   = r_col;
    assign map_wdata = r_wdata;

endmodule

// File: tb/tb_map_blitter.sv
// Bench for map_blitter: negedge-sampling RAM, rectangle-level map model,
// per-cycle compare process and directed scenarios.
module tb_map_blitter;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       cpu_req, cpu_write;
    logic [4:0] cpu_row, cpu_col;
    logic [7:0] cpu_wdata, cpu_rdata;
    logic       cpu_ack;
    logic       eng_start, eng_mode;
    logic [7:0] eng_value;
    logic [4:0] eng_src_row, eng_src_col, eng_dst_row, eng_dst_col;
    logic [5:0] eng_rows, eng_cols;
    logic       eng_busy, eng_done;
    logic       map_cs, map_read, map_write;
    logic [4:0] map_row, map_col;
    logic [7:0] map_wdata, map_rdata;

    map_blitter dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_row(cpu_row), .cpu_col(cpu_col),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .eng_start(eng_start), .eng_mode(eng_mode), .eng_value(eng_value),
        .eng_src_row(eng_src_row), .eng_src_col(eng_src_col),
        .eng_dst_row(eng_dst_row), .eng_dst_col(eng_dst_col),
        .eng_rows(eng_rows), .eng_cols(eng_cols),
        .eng_busy(eng_busy), .eng_done(eng_done),
        .map_cs(map_cs), .map_read(map_read), .map_write(map_write),
        .map_row(map_row), .map_col(map_col), .map_wdata(map_wdata), .map_rdata(map_rdata)
    );

    always #5 clock = ~clock;

    logic [7:0] mem     [32][32];
    logic [7:0] ref_mem [32][32];
    bit         wr_mask [32][32];
    logic [7:0] wr_val  [32][32];
    logic [7:0] ram_q = 8'h00;
    bit         ram_ready = 1'b0;
    assign map_rdata = ram_q;

    int   total = 0, bad = 0;
    int   eng_wr_cnt = 0, done_cnt = 0;
    bit   eng_active = 1'b0, exp_cpu_read = 1'b0;
    logic [7:0] exp_cpu_data = 8'h00;

    function automatic logic [7:0] pattern(input int r, input int c);
        return 8'((r * 7 + c * 3) ^ 8'h96);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Map RAM B port: samples on negedge, read data registered.
    always @(negedge clock) begin
        if (!ram_ready) begin
            for (int r = 0; r < 32; r++)
                for (int c = 0; c < 32; c++)
                    mem[r][c] <= pattern(r, c);
            ram_ready <= 1'b1;
        end else if (map_cs) begin
            if (map_write) mem[map_row][map_col] <= map_wdata;
            if (map_read)  ram_q <= mem[map_row][map_col];
        end
    end

    // Compare process: every RAM access, engine write, CPU ack and done pulse.
    always @(negedge clock) begin
        if (reset_n) begin
            if (map_cs | map_read | map_write)
                check("map_ctl", {29'd0, map_cs, map_read, map_write}, map_read ? 32'd6 : 32'd5);
            if (map_write && eng_active) begin
                eng_wr_cnt++;
                check("eng_wr_in_rect", {31'd0, wr_mask[map_row][map_col]}, 32'd1);
                check("eng_wr_val", {24'd0, map_wdata}, {24'd0, wr_val[map_row][map_col]});
            end
            if (cpu_ack && exp_cpu_read)
                check("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, exp_cpu_data});
            if (eng_done) begin
                done_cnt++;
                check("done_busy", {31'd0, eng_busy}, 32'd1);
            end
        end
    end

    // Rectangle model: applies the first 'limit' cells to ref_mem, marks all cells.
    task automatic model_op(input logic mode, input logic [7:0] val,
                            input int sr, input int sc, input int dr, input int dc,
                            input int rows, input int cols, input int limit);
        int R, C, n, tr, tc;
        logic [7:0] v;
        R = (rows > 32) ? 32 : rows;
        C = (cols > 32) ? 32 : cols;
        n = 0;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                wr_mask[r][c] = 1'b0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                tr = (dr + r) % 32;
                tc = (dc + c) % 32;
                v  = mode ? ref_mem[(sr + r) % 32][(sc + c) % 32] : val;
                wr_mask[tr][tc] = 1'b1;
                wr_val[tr][tc]  = v;
                if (n < limit) ref_mem[tr][tc] = v;
                n++;
            end
    endtask

    // One CPU access, called just after a posedge; ends just after a posedge.
    task automatic cpu_access(input logic wr, input logic [4:0] row, input logic [4:0] col,
                              input logic [7:0] wd, output logic [7:0] rd);
        int n;
        bit got;
        exp_cpu_read = ~wr;
        exp_cpu_data = ref_mem[row][col];
        cpu_req = 1'b1; cpu_write = wr; cpu_row = row; cpu_col = col; cpu_wdata = wd;
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clock);
            n++;
            if (cpu_ack) got = 1'b1;
        end
        check("cpu_ack_latency", n, 32'd3);
        rd = cpu_rdata;
        if (wr) ref_mem[row][col] = wd;
        @(posedge clock); #1;
        cpu_req = 1'b0; cpu_write = 1'b0;
    endtask

    // One engine run, called just after a posedge; ends just after a posedge.
    task automatic run_eng(input logic mode, input logic [7:0] val,
                           input logic [4:0] sr, input logic [4:0] sc,
                           input logic [4:0] dr, input logic [4:0] dc,
                           input logic [5:0] rows, input logic [5:0] cols,
                           input int exp_lat, input int exp_wr, input int restart_n);
        int n, wr0;
        bit got;
        model_op(mode, val, sr, sc, dr, dc, int'(rows), int'(cols), 1 << 20);
        wr0 = eng_wr_cnt;
        eng_active = 1'b1;
        eng_mode = mode; eng_value = val; eng_src_row = sr; eng_src_col = sc;
        eng_dst_row = dr; eng_dst_col = dc; eng_rows = rows; eng_cols = cols;
        eng_start = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 4000) begin
            @(negedge clock);
            n++;
            if (n == 1) check("busy_before", {31'd0, eng_busy}, 32'd0);
            if (n == 2) begin
                eng_start = 1'b0;
                check("busy_after_start", {31'd0, eng_busy}, 32'd1);
            end
            if (restart_n != 0 && n == restart_n) begin
                eng_start = 1'b1; eng_value = ~val; eng_dst_row = dr + 5'd3;
            end
            if (restart_n != 0 && n == restart_n + 1) eng_start = 1'b0;
            if (eng_done) got = 1'b1;
        end
        check("eng_done_latency", n, exp_lat);
        @(negedge clock);
        check("busy_cleared", {30'd0, eng_busy, eng_done}, 32'd0);
        eng_active = 1'b0;
        check("eng_write_count", eng_wr_cnt - wr0, exp_wr);
        @(posedge clock); #1;
    endtask

    task automatic scan_mem(input string nm);
        int mism;
        mism = 0;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                if (mem[r][c] !== ref_mem[r][c]) mism++;
        check(nm, mism, 32'd0);
    endtask

    logic [7:0] rd;
    int d0, wr0;

    initial begin
        reset_n = 1'b0;
        cpu_req = 1'b0; cpu_write = 1'b0; cpu_row = 5'd0; cpu_col = 5'd0; cpu_wdata = 8'd0;
        eng_start = 1'b0; eng_mode = 1'b0; eng_value = 8'd0;
        eng_src_row = 5'd0; eng_src_col = 5'd0; eng_dst_row = 5'd0; eng_dst_col = 5'd0;
        eng_rows = 6'd0; eng_cols = 6'd0;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                ref_mem[r][c] = pattern(r, c);

        repeat (3) @(negedge clock);
        check("reset_outputs", {cpu_rdata, cpu_ack, eng_busy, eng_done, map_cs, map_read,
                                map_write, map_row, map_col, map_wdata}, 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // CPU write then read back
        cpu_access(1'b1, 5'd3, 5'd7, 8'h5A, rd);
        cpu_access(1'b0, 5'd3, 5'd7, 8'h00, rd);
        check("cpu_read_3_7", {24'd0, rd}, 32'h5A);

        // Full-map FILL; 33 columns clamp to 32
        run_eng(1'b0, 8'h20, 5'd0, 5'd0, 5'd0, 5'd0, 6'd32, 6'd33, 1026, 1024, 0);
        scan_mem("mem_after_full_fill");
        cpu_access(1'b0, 5'd31, 5'd31, 8'h00, rd);
        check("fill_corner", {24'd0, rd}, 32'h20);

        // Wrapping FILL at (30,30)
        run_eng(1'b0, 8'h11, 5'd0, 5'd0, 5'd30, 5'd30, 6'd4, 6'd4, 18, 16, 0);
        cpu_access(1'b0, 5'd0, 5'd1, 8'h00, rd);
        check("wrap_fill_0_1", {24'd0, rd}, 32'h11);
        cpu_access(1'b0, 5'd29, 5'd30, 8'h00, rd);
        check("wrap_neighbour_row29", {24'd0, rd}, 32'h20);
        cpu_access(1'b0, 5'd30, 5'd2, 8'h00, rd);
        check("wrap_neighbour_col2", {24'd0, rd}, 32'h20);

        // COPY 2x2 (0,0)->(10,10) with a CPU read colliding with the second read slot
        cpu_access(1'b1, 5'd0, 5'd0, 8'hA1, rd);
        cpu_access(1'b1, 5'd0, 5'd1, 8'hB2, rd);
        cpu_access(1'b1, 5'd1, 5'd0, 8'hC3, rd);
        cpu_access(1'b1, 5'd1, 5'd1, 8'hD4, rd);
        fork
            run_eng(1'b1, 8'h00, 5'd0, 5'd0, 5'd10, 5'd10, 6'd2, 6'd2, 15, 4, 0);
            begin
                repeat (4) @(posedge clock);
                #1;
                cpu_access(1'b0, 5'd1, 5'd1, 8'h00, rd);
                check("mid_copy_read", {24'd0, rd}, 32'hD4);
            end
        join
        cpu_access(1'b0, 5'd11, 5'd11, 8'h00, rd);
        check("copy_dst_11_11", {24'd0, rd}, 32'hD4);
        cpu_access(1'b0, 5'd10, 5'd10, 8'h00, rd);
        check("copy_dst_10_10", {24'd0, rd}, 32'hA1);

        // Empty rectangle, then a restart attempt while busy
        run_eng(1'b0, 8'h99, 5'd0, 5'd0, 5'd4, 5'd4, 6'd0, 6'd5, 2, 0, 0);
        d0 = done_cnt;
        run_eng(1'b0, 8'h33, 5'd0, 5'd0, 5'd20, 5'd20, 6'd2, 6'd2, 6, 4, 3);
        repeat (6) @(negedge clock);
        check("single_done", done_cnt - d0, 32'd1);
        @(posedge clock); #1;

        // Reset in the middle of a full FILL
        model_op(1'b0, 8'h77, 0, 0, 0, 0, 32, 32, 48);
        wr0 = eng_wr_cnt;
        eng_active = 1'b1;
        eng_mode = 1'b0; eng_value = 8'h77; eng_dst_row = 5'd0; eng_dst_col = 5'd0;
        eng_rows = 6'd32; eng_cols = 6'd32; eng_start = 1'b1;
        @(posedge clock); #1;
        eng_start = 1'b0;
        repeat (49) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("reset_abort_outputs", {cpu_rdata, cpu_ack, eng_busy, eng_done, map_cs, map_read,
                                      map_write, map_row, map_col, map_wdata}, 32'd0);
        check("partial_writes", eng_wr_cnt - wr0, 32'd48);
        eng_active = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("busy_after_reset", {31'd0, eng_busy}, 32'd0);
        end
        @(posedge clock); #1;
        run_eng(1'b0, 8'h55, 5'd0, 5'd0, 5'd5, 5'd5, 6'd1, 6'd3, 5, 3, 0);
        cpu_access(1'b0, 5'd5, 5'd7, 8'h00, rd);
        check("post_reset_fill", {24'd0, rd}, 32'h55);
        cpu_access(1'b0, 5'd1, 5'd15, 8'h00, rd);
        check("partial_last_cell", {24'd0, rd}, 32'h77);
        cpu_access(1'b0, 5'd1, 5'd16, 8'h00, rd);
        check("partial_untouched", {24'd0, rd}, 32'h20);
        scan_mem("mem_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
